demux1_2_buf: RTL

- 1:2 steering stage with valid/ready handshake: one producer stream of N-bit words is routed to output A or output B by a per-word select.
- Each output has a 2-entry buffer, so backpressure on one output never stalls words bound for the other output while there is room.
- Sits after the result/writeback path, where one producer must feed two consumers, for example the register-file write port and the store/forward path.
- Complements the 2:1 select muxes already used in the datapath.

---
 rtl/demux1_2_buf_pkg.sv | 17 +
 rtl/demux1_2_buf_fifo2.sv | 66 ++++++
 rtl/demux1_2_buf.sv | 70 +++++++
 3 files changed

// File: rtl/demux1_2_buf_pkg.sv
// Shared definitions for the 1:2 buffered steering stage: select encodings,
// per-output buffer depth and the pointer/occupancy types of the 2-entry FIFOs.
package demux1_2_buf_pkg;

    localparam logic SEL_A     = 1'b0;
    localparam logic SEL_B     = 1'b1;
    localparam int   BUF_DEPTH = 2;

    typedef logic       ptr_t;
    typedef logic [1:0] cnt_t;

    // Pointers are one bit wide, so the increment wraps modulo BUF_DEPTH.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/demux1_2_buf_fifo2.sv
// Two-entry N-bit FIFO with a combinational head view; storage and pointers
// clear on reset so the head reads zero while the FIFO is empty after reset.
module demux1_2_buf_fifo2
    import demux1_2_buf_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [N-1:0] push_data,
    input  logic         pop,
    output logic [N-1:0] head_data,
    output logic         empty,
    output logic         full
);

    logic [N-1:0] mem_reg [BUF_DEPTH];
    ptr_t         wr_ptr_reg;
    ptr_t         rd_ptr_reg;
    cnt_t         count_reg;
    logic         do_push;
    logic         do_pop;

    // A push into a full FIFO or a pop from an empty one is silently ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == ptr_t'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == cnt_t'(BUF_DEPTH));

endmodule

// File: rtl/demux1_2_buf.sv
// 1:2 valid/ready steering stage: each word goes to output A or B by in_sel,
// with an independent 2-entry buffer per output so one stalled side never blocks the other.
module demux1_2_buf
    import demux1_2_buf_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sel,
    input  logic [N-1:0] in_data,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [N-1:0] a_data,
    output logic         b_valid,
    input  logic         b_ready,
    output logic [N-1:0] b_data
);

    logic a_empty;
    logic a_full;
    logic b_empty;
    logic b_full;
    logic fire;
    logic push_a;
    logic push_b;
    logic pop_a;
    logic pop_b;

    // Readiness looks only at registered fullness, never at a_ready/b_ready,
    // trading a one-cycle bubble on a full buffer for a short timing path.
    assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;
    assign fire     = in_valid && in_ready;
    assign push_a   = fire && (in_sel == SEL_A);
    assign push_b   = fire && (in_sel == SEL_B);

    assign a_valid  = !a_empty;
    assign b_valid  = !b_empty;
    assign pop_a    = a_valid && a_ready;
    assign pop_b    = b_valid && b_ready;

    demux1_2_buf_fifo2 #(
        .N(N)
    ) u_buf_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (pop_a),
        .head_data (a_data),
        .empty     (a_empty),
        .full      (a_full)
    );

    demux1_2_buf_fifo2 #(
        .N(N)
    ) u_buf_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (pop_b),
        .head_data (b_data),
        .empty     (b_empty),
        .full      (b_full)
    );

endmodule
